psram_qpi_responder: RTL and testbench
======================================

PSRAM_QPI_RESPONDER -- requirements
Module: psram_qpi_responder

Interface
REQ-001 Parameter ADDR_BITS, default 10, sets the internal byte array to 2**ADDR_BITS bytes; only address bits [ADDR_BITS-1:0] are used.
REQ-002 Parameter WAIT_CYCLES, default 6, sets the QPI read wait cycles between the last address nibble and the first data nibble.
REQ-003 i_clkRAM  input  1  single clock, also the serial clock; all sampling on posedge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 i_psram_cs  input  1  chip select, active-low; frames one transaction.
REQ-006 i_sio  input  4  SIO[3:0] from the initiator; SPI mode uses i_sio[0] only.
REQ-007 o_sio  output  4  SIO[3:0] driven to the initiator; registered.
REQ-008 o_sio_oe  output  4  per-pin output enable, 1 = drive; registered.
REQ-009 o_qpi_mode  output  1  1 = device in QPI mode.
REQ-010 o_cmd_err  output  1  one-cycle pulse on an unsupported command.
REQ-011 o_wr_strobe  output  1  one-cycle pulse when a byte is committed to the array.

Function
REQ-012 A frame cycle SHALL be a posedge of i_clkRAM with i_psram_cs=0; cycles are numbered from 1 within a frame.
REQ-013 The FSM SHALL have states IDLE, CMD, ADDR, WAIT, WDATA, RDATA, IGNORE.
REQ-014 IDLE -> CMD on the first frame cycle; any posedge with i_psram_cs=1 SHALL return to IDLE from any state, discarding partial nibbles or bytes.
REQ-015 SPI mode: CMD samples 8 bits on i_sio[0], MSB first, cycles 1-8.
REQ-016 SPI mode: 0x35 SHALL set o_qpi_mode at the next posedge with i_psram_cs=1.
REQ-017 SPI mode: any other command SHALL go to IGNORE and pulse o_cmd_err.
REQ-018 QPI mode: CMD samples 2 nibbles on i_sio[3:0], high nibble first, cycles 1-2.
REQ-019 QPI mode, 0x38 (write): ADDR takes 6 nibbles, MSB first, cycles 3-8; then WDATA.
REQ-020 WDATA takes nibble pairs, high nibble first; on each low nibble it writes the byte at the current address, pulses o_wr_strobe, and increments the address.
REQ-021 QPI mode, 0xEB (read): ADDR takes cycles 3-8, WAIT takes cycles 9..8+WAIT_CYCLES with o_sio_oe=0, then RDATA.
REQ-022 RDATA: data nibble k (k>=1) SHALL be driven on o_sio with o_sio_oe=4'hF in the cycle after frame posedge 8+WAIT_CYCLES+k-1, high nibble first; the address increments after each low nibble.
REQ-023 QPI mode: 0xF5 SHALL clear o_qpi_mode at the next i_psram_cs=1 posedge.
REQ-024 QPI mode: any other command goes to IGNORE and pulses o_cmd_err.
REQ-025 The address SHALL wrap from 2**ADDR_BITS-1 to 0 during bursts; upper address bits are ignored with no error.
REQ-026 o_sio_oe SHALL be 0 in every state except RDATA, and 0 on the first posedge with i_psram_cs=1.
REQ-027 A frame ending mid-byte in WDATA SHALL NOT write; an already committed byte remains.
REQ-028 A frame shorter than the command length SHALL have no effect.

Reset
REQ-029 While reset=1: state=IDLE, o_qpi_mode=0, o_sio=0, o_sio_oe=0, o_cmd_err=0, o_wr_strobe=0, address=0.
REQ-030 The memory array SHALL NOT be cleared by reset; its content is undefined until written.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately; after release, the device waits for i_psram_cs=1 then 0 before decoding.

Verification
REQ-032 After reset, SPI 0x35 then CS high -> o_qpi_mode=1 one cycle after CS rise, o_cmd_err never pulses.
REQ-033 QPI 0x38, addr 0x000010, data 0xA5,0x3C -> two o_wr_strobe pulses; 0xEB to 0x000010 -> oe=F from cycle 15, nibbles A,5,3,C.
REQ-034 With ADDR_BITS=10, write 0x11,0x22 at 0x0003FF -> read at 0x000000 returns 0x22 (wrap).
REQ-035 Write 0x38, addr, then one nibble, then CS high -> no o_wr_strobe; read back returns the old value.
REQ-036 SPI 0x38 before QPI enable -> o_cmd_err pulse, no write, o_sio_oe=0 throughout; QPI 0xF5 -> o_qpi_mode=0.
REQ-037 Reset pulse during the RDATA of a read burst -> o_sio_oe=0 immediately; the next full frame decodes in SPI mode.

Source files
------------

// File: rtl/psram_qpi_responder_if.sv
// ---------------------------------------------------------------------------
// psram_qpi_responder_if
// Pin bundle between a PSRAM initiator (master) and the QPI responder model
// (slave). Clock and reset are not part of the bundle.
//   i_psram_cs  : chip select, active-low, frames one transaction
//   i_sio       : SIO[3:0] from the initiator (SPI mode uses bit 0 only)
//   o_sio       : SIO[3:0] driven back to the initiator
//   o_sio_oe    : per-pin output enable, 1 = responder drives the pin
//   o_qpi_mode  : 1 = responder is in QPI mode
//   o_cmd_err   : one-cycle pulse on an unsupported command
//   o_wr_strobe : one-cycle pulse when a byte is committed to the array
// ---------------------------------------------------------------------------
interface psram_qpi_responder_if;
  logic       i_psram_cs;
  logic [3:0] i_sio;
  logic [3:0] o_sio;
  logic [3:0] o_sio_oe;
  logic       o_qpi_mode;
  logic       o_cmd_err;
  logic       o_wr_strobe;

  modport master (
    output i_psram_cs, i_sio,
    input  o_sio, o_sio_oe, o_qpi_mode, o_cmd_err, o_wr_strobe
  );

  modport slave (
    input  i_psram_cs, i_sio,
    output o_sio, o_sio_oe, o_qpi_mode, o_cmd_err, o_wr_strobe
  );
endinterface

// File: rtl/psram_qpi_responder.sv
// ---------------------------------------------------------------------------
// psram_qpi_responder
// Behavioural-but-synthesizable PSRAM responder supporting SPI/QPI mode
// switching, QPI quad write (0x38) and QPI fast quad read (0xEB) into a
// 2**ADDR_BITS byte array. Everything is sampled on the rising edge of
// i_clkRAM, which doubles as the serial clock.
// Ports:
//   i_clkRAM : clock / serial clock
//   reset    : asynchronous, active-high
//   bus      : psram_qpi_responder_if.slave (chip select, SIO in/out,
//              output enables, mode flag, error and write strobes)
// Parameters:
//   ADDR_BITS   : log2 of the array size; upper address bits are dropped
//   WAIT_CYCLES : read wait cycles between last address and first data nibble
// ---------------------------------------------------------------------------
module psram_qpi_responder #(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 6
) (
  input logic                   i_clkRAM,
  input logic                   reset,
  psram_qpi_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, WAIT, WDATA, RDATA, IGNORE
  } state_t;

  // Counter values seen on the last address cycle (8) and last wait cycle.
  localparam logic [7:0] ADDR_LAST = 8'd7;
  localparam logic [7:0] WAIT_LAST = 8'(7 + WAIT_CYCLES);

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [7:0]             cmd_q, cmd_d;
  logic [3:0]             hold_q, hold_d;
  logic [ADDR_BITS-1:0]   ptr_q, ptr_d;
  logic                   is_rd_q, is_rd_d;
  logic                   half_q, half_d;
  logic                   armed_q, armed_d;
  logic                   pend_on_q, pend_on_d;
  logic                   pend_off_q, pend_off_d;
  logic                   qpi_q, qpi_d;
  logic [3:0]             sio_q, sio_d;
  logic [3:0]             oe_q, oe_d;
  logic                   err_q, err_d;
  logic                   wstb_q, wstb_d;
  logic                   mem_we;
  logic [7:0]             cmd_next;
  logic [ADDR_BITS-1:0]   addr_next;

  logic [7:0] mem [2**ADDR_BITS];

  assign cmd_next  = qpi_q ? {cmd_q[3:0], bus.i_sio} : {cmd_q[6:0], bus.i_sio[0]};
  // Address shifts in nibble-wise; bits above ADDR_BITS fall off the top.
  assign addr_next = ADDR_BITS'({ptr_q, bus.i_sio});

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    hold_d     = hold_q;
    ptr_d      = ptr_q;
    is_rd_d    = is_rd_q;
    half_d     = half_q;
    armed_d    = armed_q;
    pend_on_d  = pend_on_q;
    pend_off_d = pend_off_q;
    qpi_d      = qpi_q;
    sio_d      = 4'h0;
    oe_d       = 4'h0;
    err_d      = 1'b0;
    wstb_d     = 1'b0;
    mem_we     = 1'b0;

    if (bus.i_psram_cs) begin
      // Frame boundary: drop any partial work and apply a pending mode switch.
      state_d    = IDLE;
      armed_d    = 1'b1;
      cnt_d      = 8'd0;
      half_d     = 1'b0;
      pend_on_d  = 1'b0;
      pend_off_d = 1'b0;
      if (pend_on_q)  qpi_d = 1'b1;
      if (pend_off_q) qpi_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // After a reset the device ignores the frame in progress.
          if (armed_q) begin
            cmd_d   = qpi_q ? {4'h0, bus.i_sio} : {7'h00, bus.i_sio[0]};
            cnt_d   = 8'd1;
            state_d = CMD;
          end
        end
        CMD: begin
          cmd_d = cmd_next;
          cnt_d = cnt_q + 8'd1;
          if (qpi_q && cnt_q == 8'd1) begin
            case (cmd_next)
              8'h38:   begin is_rd_d = 1'b0; state_d = ADDR; end
              8'hEB:   begin is_rd_d = 1'b1; state_d = ADDR; end
              8'hF5:   begin pend_off_d = 1'b1; state_d = IGNORE; end
              default: begin err_d = 1'b1; state_d = IGNORE; end
            endcase
          end else if (!qpi_q && cnt_q == 8'd7) begin
            if (cmd_next == 8'h35) begin
              pend_on_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IGNORE;
          end
        end
        ADDR: begin
          ptr_d = addr_next;
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == ADDR_LAST) begin
            half_d = 1'b0;
            if (!is_rd_q) begin
              state_d = WDATA;
            end else if (WAIT_CYCLES == 0) begin
              sio_d   = mem[addr_next][7:4];
              oe_d    = 4'hF;
              half_d  = 1'b1;
              state_d = RDATA;
            end else begin
              state_d = WAIT;
            end
          end
        end
        WAIT: begin
          cnt_d = cnt_q + 8'd1;
          // Present the first high nibble on the last wait cycle so it is
          // valid for the initiator's next sampling edge.
          if (cnt_q == WAIT_LAST) begin
            sio_d   = mem[ptr_q][7:4];
            oe_d    = 4'hF;
            half_d  = 1'b1;
            state_d = RDATA;
          end
        end
        RDATA: begin
          oe_d = 4'hF;
          if (half_q) begin
            sio_d  = mem[ptr_q][3:0];
            ptr_d  = ptr_q + 1'b1;
            half_d = 1'b0;
          end else begin
            sio_d  = mem[ptr_q][7:4];
            half_d = 1'b1;
          end
        end
        WDATA: begin
          if (!half_q) begin
            hold_d = bus.i_sio;
            half_d = 1'b1;
          end else begin
            mem_we = 1'b1;
            wstb_d = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            half_d = 1'b0;
          end
        end
        IGNORE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clkRAM or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      ptr_q      <= '0;
      is_rd_q    <= 1'b0;
      half_q     <= 1'b0;
      armed_q    <= 1'b0;
      pend_on_q  <= 1'b0;
      pend_off_q <= 1'b0;
      qpi_q      <= 1'b0;
      sio_q      <= 4'h0;
      oe_q       <= 4'h0;
      err_q      <= 1'b0;
      wstb_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      is_rd_q    <= is_rd_d;
      half_q     <= half_d;
      armed_q    <= armed_d;
      pend_on_q  <= pend_on_d;
      pend_off_q <= pend_off_d;
      qpi_q      <= qpi_d;
      sio_q      <= sio_d;
      oe_q       <= oe_d;
      err_q      <= err_d;
      wstb_q     <= wstb_d;
    end
  end

  // Shift registers whose content is meaningless outside a frame.
  always_ff @(posedge i_clkRAM) begin
    cmd_q  <= cmd_d;
    hold_q <= hold_d;
  end

  // Array content survives reset; mem_we is only raised in WDATA.
  always_ff @(posedge i_clkRAM) begin
    if (mem_we) mem[ptr_q] <= {hold_q, bus.i_sio};
  end

  assign bus.o_sio       = sio_q;
  assign bus.o_sio_oe    = oe_q;
  assign bus.o_qpi_mode  = qpi_q;
  assign bus.o_cmd_err   = err_q;
  assign bus.o_wr_strobe = wstb_q;

endmodule

// File: tb/tb_psram_qpi_responder.sv
// ---------------------------------------------------------------------------
// tb_psram_qpi_responder
// Directed stimulus for the PSRAM QPI responder. Stimulus tasks push the
// expected observable events (mode change, command error, write strobe, read
// nibble with its frame cycle) into a queue; an independent monitor pops and
// compares whenever the DUT shows one of those events.
// ---------------------------------------------------------------------------
module tb_psram_qpi_responder;
  localparam int W      = 6;
  localparam int K_WR   = 0;
  localparam int K_RD   = 1;
  localparam int K_ERR  = 2;
  localparam int K_MODE = 3;

  typedef struct {
    int         kind;
    logic [3:0] val;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exq[$];
  int   checks = 0;
  int   errors = 0;
  int   fcyc   = 0;
  logic prev_qpi = 1'b0;

  psram_qpi_responder_if bus();

  psram_qpi_responder #(.ADDR_BITS(10), .WAIT_CYCLES(W)) dut (
    .i_clkRAM (clk),
    .reset    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  function automatic string kname(int k);
    case (k)
      K_WR:    return "wr_strobe";
      K_RD:    return "read_nibble";
      K_ERR:   return "cmd_err";
      default: return "qpi_mode";
    endcase
  endfunction

  task automatic push(int kind, logic [3:0] val, int cyc);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = cyc;
    exq.push_back(e);
  endtask

  task automatic check_evt(int kind, logic [3:0] val, int cyc);
    exp_t e;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event val=%h cyc=%0d, required no event", kname(kind), val, cyc);
    end else begin
      e = exq.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind: actual %s required %s", kname(kind), kname(e.kind));
      end else if ((kind == K_RD || kind == K_MODE) && val !== e.val) begin
        errors++;
        $display("FAIL %s: actual %h required %h (cyc %0d)", kname(kind), val, e.val, cyc);
      end else if (kind == K_RD && cyc != e.cyc) begin
        errors++;
        $display("FAIL read_cycle: nibble %h at cycle %0d, required cycle %0d", val, cyc, e.cyc);
      end
    end
  endtask

  task automatic chk(string name, logic [3:0] act, logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Monitor: sample just after each rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (rst || bus.i_psram_cs) fcyc = 0;
      else                       fcyc++;
      if (bus.o_qpi_mode !== prev_qpi) begin
        check_evt(K_MODE, {3'b000, bus.o_qpi_mode}, fcyc);
        prev_qpi = bus.o_qpi_mode;
      end
      if (bus.o_cmd_err)   check_evt(K_ERR, 4'h0, fcyc);
      if (bus.o_wr_strobe) check_evt(K_WR, 4'h0, fcyc);
      if (bus.o_sio_oe === 4'hF) begin
        check_evt(K_RD, bus.o_sio, fcyc);
      end else if (bus.o_sio_oe !== 4'h0) begin
        checks++;
        errors++;
        $display("FAIL sio_oe: actual %h required 0 or F", bus.o_sio_oe);
      end
    end
  end

  task automatic nib(logic [3:0] v);
    @(negedge clk);
    bus.i_psram_cs = 1'b0;
    bus.i_sio      = v;
  endtask

  task automatic cs_high(int n);
    repeat (n) begin
      @(negedge clk);
      bus.i_psram_cs = 1'b1;
      bus.i_sio      = 4'h0;
    end
  endtask

  task automatic spi_bits(logic [7:0] c);
    for (int i = 7; i >= 0; i--) nib({3'b000, c[i]});
  endtask

  task automatic qpi_hdr(logic [7:0] c, logic [23:0] a);
    nib(c[7:4]);
    nib(c[3:0]);
    for (int i = 5; i >= 0; i--) nib(a[4*i +: 4]);
  endtask

  task automatic qpi_write(logic [23:0] a, logic [15:0] d, int n);
    repeat (n) push(K_WR, 4'h0, 0);
    qpi_hdr(8'h38, a);
    for (int j = 0; j < n; j++) begin
      nib(d[15-8*j -: 4]);
      nib(d[11-8*j -: 4]);
    end
    cs_high(2);
  endtask

  // Nibble k of the burst is expected at frame cycle 7+W+k.
  task automatic qpi_read(logic [23:0] a, logic [15:0] d, int n);
    for (int j = 0; j < 2*n; j++) begin
      if (j % 2 == 0) push(K_RD, d[15-8*(j/2) -: 4], 8 + W + j);
      else            push(K_RD, d[11-8*(j/2) -: 4], 8 + W + j);
    end
    qpi_hdr(8'hEB, a);
    repeat (W) nib(4'h0);
    repeat (2*n - 1) nib(4'h0);
    cs_high(2);
  endtask

  initial begin : driver
    rst            = 1'b1;
    bus.i_psram_cs = 1'b1;
    bus.i_sio      = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_sio",      bus.o_sio, 4'h0);
    chk("rst_sio_oe",   bus.o_sio_oe, 4'h0);
    chk("rst_qpi_mode", {3'b000, bus.o_qpi_mode}, 4'h0);
    chk("rst_cmd_err",  {3'b000, bus.o_cmd_err}, 4'h0);
    chk("rst_wr_strobe", {3'b000, bus.o_wr_strobe}, 4'h0);
    @(negedge clk);
    rst = 1'b0;
    cs_high(2);

    // Write command while still in SPI mode: error, no write, no drive.
    push(K_ERR, 4'h0, 0);
    spi_bits(8'h38);
    cs_high(2);

    // Enter QPI: mode must be visible right after the first CS-high edge.
    push(K_MODE, 4'h1, 0);
    spi_bits(8'h35);
    cs_high(1);
    @(posedge clk);
    #1;
    chk("qpi_after_cs_rise", {3'b000, bus.o_qpi_mode}, 4'h1);
    cs_high(2);

    // Basic write / read burst.
    qpi_write(24'h000010, 16'hA53C, 2);
    qpi_read(24'h000010, 16'hA53C, 2);

    // Wrap at the top of a 1 KiB array.
    qpi_write(24'h0003FF, 16'h1122, 2);
    qpi_read(24'h000000, 16'h2200, 1);
    qpi_read(24'h0003FF, 16'h1122, 2);

    // Frame ends after one data nibble: nothing is written.
    qpi_hdr(8'h38, 24'h000010);
    nib(4'hF);
    cs_high(2);
    qpi_read(24'h000010, 16'hA500, 1);

    // Upper address bits are ignored.
    qpi_read(24'hFFFC10, 16'hA53C, 2);

    // Unsupported QPI command.
    push(K_ERR, 4'h0, 0);
    nib(4'h1);
    nib(4'h2);
    cs_high(2);

    // Truncated 0xF5 has no effect; complete 0xF5 leaves QPI mode.
    nib(4'hF);
    cs_high(2);
    push(K_MODE, 4'h0, 0);
    nib(4'hF);
    nib(4'h5);
    cs_high(2);

    // Back to QPI, then reset in the middle of a read burst.
    push(K_MODE, 4'h1, 0);
    spi_bits(8'h35);
    cs_high(2);
    push(K_RD, 4'hA, 8 + W);
    push(K_RD, 4'h5, 9 + W);
    push(K_MODE, 4'h0, 0);
    qpi_hdr(8'hEB, 24'h000010);
    repeat (W) nib(4'h0);
    nib(4'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("oe_on_reset", bus.o_sio_oe, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Still inside the aborted frame: this must not be decoded.
    spi_bits(8'h35);
    cs_high(2);
    // Fresh frame decodes in SPI mode.
    push(K_MODE, 4'h1, 0);
    spi_bits(8'h35);
    cs_high(4);

    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL pending_events: actual %0d left, required 0 (next %s)", exq.size(), kname(exq[0].kind));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
